// File: rtl/hart_0_retire_trace_capture.sv
// hart 0 retire trace capture: arms on an optional PC trigger, buffers retirements, drains to a reader.
// Latency: a captured record shows on out_valid/out_data one cycle after it retires.
// Backpressure: out_ready stalls draining; a full FIFO drops new records and counts them in drop_count.
// Optional: define RETIRE_TRACE_CAPTURE_TIMESTAMP_EN to store a 32-bit cycle count in out_data[99:68].

// Generic single-clock FIFO with a registered head entry.
// Latency: a push into an empty FIFO is visible on head_vld/head_dat the next cycle.
// Backpressure: a push while full is ignored; a pop in the same cycle does not make room.
module hart_0_retire_trace_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   fill_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign head_vld = (fill != '0);

    // Push/pop qualification and next pointer/fill values; space is judged on the fill at cycle start.
    always_comb begin
        push_ok    = push_vld && (fill != FULL_LVL);
        pop_ok     = pop_rdy && head_vld;
        rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
        fill_nxt   = fill + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and fill level, wrapping naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            fill   <= fill_nxt;
        end
    end

    // Head register: reloads the next head entry, bypassing the array when that entry is written now,
    // and holds its last value once the FIFO goes empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_dat <= '0;
        end else if (fill_nxt != '0) begin
            if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
                head_dat <= push_dat;
            end else begin
                head_dat <= mem[rd_ptr_nxt];
            end
        end
    end
endmodule

module hart_0_retire_trace_capture #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_enable,
    input  logic                     cfg_trig_en,
    input  logic [31:0]              cfg_trig_addr,
    input  logic [CNT_W-1:0]         cfg_stop_count,
    input  logic                     trace_valid,
    input  logic [31:0]              trace_iaddr,
    input  logic [31:0]              trace_insn,
    input  logic [1:0]               trace_priv,
    input  logic                     trace_exception,
    input  logic                     trace_interrupt,
    input  logic                     cease,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef RETIRE_TRACE_CAPTURE_TIMESTAMP_EN
    output logic [99:0]              out_data,
`else
    output logic [67:0]              out_data,
`endif
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         capture_count,
    output logic [CNT_W-1:0]         drop_count
);
`ifdef RETIRE_TRACE_CAPTURE_TIMESTAMP_EN
    localparam int DATA_W = 100;
`else
    localparam int DATA_W = 68;
`endif
    localparam logic [$clog2(DEPTH):0] FULL_LVL = ($clog2(DEPTH)+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_STOPPED = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               trig_hit;
    logic               cand;
    logic               leave_idle;
    logic               fifo_full;
    logic               accept;
    logic               drop_evt;
    logic               stop_hit;
    logic [CNT_W-1:0]   cap_inc;
    logic [DATA_W-1:0]  rec_dat;

    assign trig_hit  = trace_valid && (trace_iaddr == cfg_trig_addr);
    assign fifo_full = (fill_level == FULL_LVL);
    assign accept    = cand && !fifo_full;
    assign drop_evt  = cand && fifo_full;
    assign cap_inc   = capture_count + CNT_W'(1);
    assign stop_hit  = (cfg_stop_count != '0) && (cap_inc == cfg_stop_count);
    assign state     = state_q;

`ifdef RETIRE_TRACE_CAPTURE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter stamped onto every accepted record.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign rec_dat = {cycle_cnt, trace_priv, trace_interrupt, trace_exception, trace_insn, trace_iaddr};
`else
    assign rec_dat = {trace_priv, trace_interrupt, trace_exception, trace_insn, trace_iaddr};
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; dropping cfg_enable wins over every other transition.
    always_comb begin
        state_d = state_q;
        if (!cfg_enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = cfg_trig_en ? S_ARMED : S_CAPTURE;
                S_ARMED:   if (trig_hit) state_d = S_CAPTURE;
                S_CAPTURE: if (cease || (accept && stop_hit)) state_d = S_STOPPED;
                S_STOPPED: state_d = S_STOPPED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: which retirements are capture candidates, and when the counters restart.
    always_comb begin
        cand       = 1'b0;
        leave_idle = 1'b0;
        if (cfg_enable) begin
            case (state_q)
                S_IDLE:    leave_idle = 1'b1;
                S_ARMED:   cand = trig_hit;
                S_CAPTURE: cand = trace_valid;
                default:   cand = 1'b0;
            endcase
        end
    end

    // Capture and drop counters; both restart on leaving IDLE, drops saturate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capture_count <= '0;
            drop_count    <= '0;
        end else if (leave_idle) begin
            capture_count <= '0;
            drop_count    <= '0;
        end else begin
            if (accept) begin
                capture_count <= cap_inc;
            end
            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    hart_0_retire_trace_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (accept),
        .push_dat (rec_dat),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (out_data),
        .fill     (fill_level)
    );
endmodule

// File: tb/tb_hart_0_retire_trace_capture.sv
// Directed bench for hart_0_retire_trace_capture: basic capture, trigger, overflow, stop count, cease, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected records come from the rec() packing function and hand-written address lists.
module tb_hart_0_retire_trace_capture;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_STOPPED = 2'd3;

    logic              clock;
    logic              reset;
    logic              cfg_enable;
    logic              cfg_trig_en;
    logic [31:0]       cfg_trig_addr;
    logic [CNT_W-1:0]  cfg_stop_count;
    logic              trace_valid;
    logic [31:0]       trace_iaddr;
    logic [31:0]       trace_insn;
    logic [1:0]        trace_priv;
    logic              trace_exception;
    logic              trace_interrupt;
    logic              cease;
    logic              out_valid;
    logic              out_ready;
`ifdef RETIRE_TRACE_CAPTURE_TIMESTAMP_EN
    logic [99:0]       out_data;
`else
    logic [67:0]       out_data;
`endif
    logic [1:0]        state;
    logic [3:0]        fill_level;
    logic [CNT_W-1:0]  capture_count;
    logic [CNT_W-1:0]  drop_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [67:0] held;

    hart_0_retire_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .cfg_enable      (cfg_enable),
        .cfg_trig_en     (cfg_trig_en),
        .cfg_trig_addr   (cfg_trig_addr),
        .cfg_stop_count  (cfg_stop_count),
        .trace_valid     (trace_valid),
        .trace_iaddr     (trace_iaddr),
        .trace_insn      (trace_insn),
        .trace_priv      (trace_priv),
        .trace_exception (trace_exception),
        .trace_interrupt (trace_interrupt),
        .cease           (cease),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .state           (state),
        .fill_level      (fill_level),
        .capture_count   (capture_count),
        .drop_count      (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected 68-bit record for a retirement driven by retire(a).
    function automatic logic [67:0] rec(input logic [31:0] a);
        return {a[3:2], a[4], a[5], a ^ 32'h1357_9BDF, a};
    endfunction

    task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic retire(input logic [31:0] a);
        trace_valid     = 1'b1;
        trace_iaddr     = a;
        trace_insn      = a ^ 32'h1357_9BDF;
        trace_priv      = a[3:2];
        trace_interrupt = a[4];
        trace_exception = a[5];
    endtask

    task automatic no_trace();
        trace_valid = 1'b0;
    endtask

    // Pop n entries, checking each head against the expected address queue before it is consumed.
    task automatic drain(input int n, input string tag);
        logic [31:0] a;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = exp_q.pop_front();
            check_eq({tag, "_vld"}, 68'(out_valid), 68'd1);
            check_eq({tag, "_dat"}, out_data[67:0], rec(a));
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic reenable();
        cfg_enable = 1'b0;
        step();
        cfg_enable = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b0;
        cfg_enable = 1'b0; cfg_trig_en = 1'b0; cfg_trig_addr = '0; cfg_stop_count = '0;
        trace_valid = 1'b0; trace_iaddr = '0; trace_insn = '0; trace_priv = '0;
        trace_exception = 1'b0; trace_interrupt = 1'b0; cease = 1'b0; out_ready = 1'b0;
        #12;
        check_eq("rst_state", 68'(state), 68'(S_IDLE));
        check_eq("rst_vld", 68'(out_valid), 68'd0);
        check_eq("rst_dat", out_data[67:0], 68'd0);
        check_eq("rst_fill", 68'(fill_level), 68'd0);
        check_eq("rst_cap", 68'(capture_count), 68'd0);
        check_eq("rst_drop", 68'(drop_count), 68'd0);
        reset = 1'b1;
        step();
        check_eq("idle_hold", 68'(state), 68'(S_IDLE));

        // Basic capture without trigger.
        cfg_enable = 1'b1;
        step();
        check_eq("basic_state", 68'(state), 68'(S_CAPTURE));
        check_eq("basic_pre_vld", 68'(out_valid), 68'd0);
        retire(32'h8000_0000);
        step();
        check_eq("basic_lat_vld", 68'(out_valid), 68'd1);
        check_eq("basic_lat_dat", out_data[67:0], rec(32'h8000_0000));
        retire(32'h8000_0004); step();
        retire(32'h8000_0008); step();
        no_trace();
        check_eq("basic_fill", 68'(fill_level), 68'd3);
        check_eq("basic_cap", 68'(capture_count), 68'd3);
        exp_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        drain(3, "basic_drain");
        check_eq("basic_empty_fill", 68'(fill_level), 68'd0);
        check_eq("basic_empty_vld", 68'(out_valid), 68'd0);
        check_eq("basic_hold_dat", out_data[67:0], rec(32'h8000_0008));

        // PC trigger.
        cfg_enable = 1'b0;
        step();
        check_eq("trig_idle", 68'(state), 68'(S_IDLE));
        cfg_enable = 1'b1; cfg_trig_en = 1'b1; cfg_trig_addr = 32'h8000_0010;
        step();
        check_eq("trig_armed", 68'(state), 68'(S_ARMED));
        retire(32'h8000_0008); step();
        retire(32'h8000_000C); step();
        check_eq("trig_wait_state", 68'(state), 68'(S_ARMED));
        check_eq("trig_wait_fill", 68'(fill_level), 68'd0);
        retire(32'h8000_0010); step();
        check_eq("trig_hit_state", 68'(state), 68'(S_CAPTURE));
        check_eq("trig_hit_fill", 68'(fill_level), 68'd1);
        retire(32'h8000_0014); step();
        no_trace();
        check_eq("trig_cap", 68'(capture_count), 68'd2);
        exp_q = '{32'h8000_0010, 32'h8000_0014};
        drain(2, "trig_drain");
        cfg_trig_en = 1'b0;

        // Overflow with the reader stalled.
        reenable();
        check_eq("ovf_state", 68'(state), 68'(S_CAPTURE));
        check_eq("ovf_cap_clr", 68'(capture_count), 68'd0);
        for (int i = 0; i < 11; i++) begin
            retire(32'h9000_0000 + 32'(4 * i));
            step();
        end
        no_trace();
        check_eq("ovf_fill", 68'(fill_level), 68'd8);
        check_eq("ovf_drop", 68'(drop_count), 68'd3);
        check_eq("ovf_cap", 68'(capture_count), 68'd8);
        check_eq("ovf_head", out_data[67:0], rec(32'h9000_0000));
        held = out_data[67:0];
        step();
        check_eq("ovf_stall_dat", out_data[67:0], held);
        out_ready = 1'b1;
        retire(32'h9000_0100);
        step();
        out_ready = 1'b0;
        no_trace();
        check_eq("ovf_pop_fill", 68'(fill_level), 68'd7);
        check_eq("ovf_pop_drop", 68'(drop_count), 68'd4);
        for (int i = 1; i < 8; i++) exp_q.push_back(32'h9000_0000 + 32'(4 * i));
        drain(7, "ovf_drain");
        check_eq("ovf_empty", 68'(fill_level), 68'd0);

        // Stop count.
        cfg_stop_count = 16'd5;
        reenable();
        for (int i = 0; i < 8; i++) begin
            retire(32'hA000_0000 + 32'(4 * i));
            step();
        end
        no_trace();
        check_eq("stop_state", 68'(state), 68'(S_STOPPED));
        check_eq("stop_cap", 68'(capture_count), 68'd5);
        check_eq("stop_drop", 68'(drop_count), 68'd0);
        check_eq("stop_fill", 68'(fill_level), 68'd5);
        cfg_enable = 1'b0;
        step();
        check_eq("stop_idle", 68'(state), 68'(S_IDLE));
        cfg_enable = 1'b1;
        cfg_stop_count = '0;
        step();
        check_eq("stop_re_state", 68'(state), 68'(S_CAPTURE));
        check_eq("stop_re_cap", 68'(capture_count), 68'd0);
        check_eq("stop_re_fill", 68'(fill_level), 68'd5);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'hA000_0000 + 32'(4 * i));
        drain(5, "stop_drain");

        // Cease together with a retirement.
        retire(32'h8000_0020);
        cease = 1'b1;
        step();
        no_trace();
        cease = 1'b0;
        check_eq("cease_state", 68'(state), 68'(S_STOPPED));
        check_eq("cease_fill", 68'(fill_level), 68'd1);
        check_eq("cease_cap", 68'(capture_count), 68'd1);
        exp_q.push_back(32'h8000_0020);
        drain(1, "cease_drain");

        // Async reset mid-cycle while holding entries.
        reenable();
        for (int i = 0; i < 4; i++) begin
            retire(32'hB000_0000 + 32'(4 * i));
            step();
        end
        no_trace();
        check_eq("arst_pre_fill", 68'(fill_level), 68'd4);
        out_ready = 1'b1;
        #1 out_ready = 1'b0;
        #1 out_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_eq("arst_state", 68'(state), 68'(S_IDLE));
        check_eq("arst_vld", 68'(out_valid), 68'd0);
        check_eq("arst_dat", out_data[67:0], 68'd0);
        check_eq("arst_fill", 68'(fill_level), 68'd0);
        check_eq("arst_cap", 68'(capture_count), 68'd0);
        out_ready = 1'b0;
        reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hart_0_retire_trace_capture.md
Name: hart_0_retire_trace_capture

Overview:
- Sits directly downstream of the hart 0 core monitor trace port.
- Consumes per-retirement trace records (PC, instruction, privilege, exception/interrupt flags) and the core's cease indication.
- Arms on an optional PC trigger, captures retirements into a small FIFO and drains them to a debug reader over valid/ready.
- Counts captured and dropped records for post-silicon and emulation scope use.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
CNT_W, 16, width of capture/drop counters and stop count

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
cfg_enable  in  1  capture enable; 0 forces IDLE
cfg_trig_en  in  1  1: wait for PC trigger before capturing
cfg_trig_addr  in  32  trigger PC
cfg_stop_count  in  CNT_W  stop after this many accepted records; 0 = unlimited
trace_valid  in  1  one instruction retired this cycle
trace_iaddr  in  32  retired PC
trace_insn  in  32  retired instruction bits
trace_priv  in  2  privilege at retirement
trace_exception  in  1  retirement took exception
trace_interrupt  in  1  retirement took interrupt
cease  in  1  hart ceased
out_valid  out  1  FIFO head valid
out_ready  in  1  reader accepts head
out_data  out  68  {priv[67:66], intr[65], exc[64], insn[63:32], iaddr[31:0]}
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 STOPPED
fill_level  out  log2(DEPTH)+1  entries held
capture_count  out  CNT_W  accepted records
drop_count  out  CNT_W  records lost to full FIFO, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, out_valid=0, out_data=0, fill_level=0, both counters=0.
- FSM:
  - IDLE -> ARMED when cfg_enable=1 and cfg_trig_en=1.
  - IDLE -> CAPTURE when cfg_enable=1 and cfg_trig_en=0.
  - ARMED -> CAPTURE when trace_valid=1 and trace_iaddr==cfg_trig_addr; the matching record is itself a capture candidate that cycle.
  - CAPTURE -> STOPPED when an accepted push makes capture_count==cfg_stop_count (stop_count!=0), or when cease=1.
  - Any state -> IDLE when cfg_enable=0; this has priority over all other transitions.
- Leaving IDLE clears capture_count and drop_count. FIFO contents are not cleared.
- Push rule: candidate = trace_valid in CAPTURE, or the trigger match in ARMED.
  - Accepted if fill_level<DEPTH at cycle start. A simultaneous pop does not free space.
  - Otherwise drop_count increments, saturating at 2^CNT_W-1.
- cease and trace_valid in the same CAPTURE cycle: the record is pushed or dropped as normal, then the FSM goes to STOPPED.
- STOPPED and IDLE accept no pushes. Draining continues in every state.
- Pop: on out_valid & out_ready, advance the read pointer.
- out_valid = (fill_level!=0). out_data = entry at the read pointer, registered storage, no combinational path from the trace inputs.
- Push-to-out_valid latency is 1 cycle. Pointers wrap modulo DEPTH.
- Simultaneous push and pop while 0<fill_level<DEPTH leaves fill_level unchanged.
- out_data holds its last value when empty. It must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro RETIRE_TRACE_CAPTURE_TIMESTAMP_EN.
- When defined: a free-running 32-bit cycle counter, reset to 0 and wrapping, is stored with each accepted record. out_data widens to 100 bits with the timestamp in [99:68].
- When undefined: no counter exists and out_data is 68 bits.

Test Plan:
- Basic capture: cfg_enable=1, trig_en=0, 3 retirements at 0x8000_0000/4/8 -> out_valid 1 cycle after the first; drained in order; capture_count=3; fill_level returns to 0.
- Trigger: trig_en=1, trig_addr=0x8000_0010, retire 0x8000_0008, 0x0C, 0x10, 0x14 -> only 0x10 and 0x14 captured; state ARMED->CAPTURE on the 0x10 cycle.
- Overflow: DEPTH=8, out_ready=0, 11 retirements -> fill_level=8, drop_count=3. Pop one entry with a same-cycle retirement -> that retirement is dropped (drop_count=4).
- Stop count: stop_count=5, 8 retirements -> capture_count=5, state=STOPPED, retirements 6-8 ignored with drop_count=0. Then cfg_enable=0->1 -> counters cleared, FIFO drains intact.
- Cease: cease=1 in the same cycle as retirement at 0x8000_0020 -> record captured, state=STOPPED next cycle.
- Async reset with 4 entries held and out_ready toggling -> all outputs 0 immediately, state=IDLE.
